// File: rtl/waiz_pkg.sv
// Shared constants and types for the waiz_benchmark sequencing logic.
package waiz_pkg;

    localparam int unsigned WIDTH          = 16;
    localparam int unsigned NFRAC          = 10;
    localparam int unsigned INPUT_SIZE     = 16;
    localparam int unsigned OUTPUT_SIZE    = 5;
    localparam int unsigned TIMEOUT_CYCLES = 1024;
    localparam int unsigned CNT_W          = 16;

    localparam int unsigned IN_IDX_W  = $clog2(INPUT_SIZE);
    localparam int unsigned OUT_IDX_W = $clog2(OUTPUT_SIZE);
    localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES);

    typedef logic signed [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/waiz_argmax.sv
// Combinational signed argmax over OUTPUT_SIZE packed words; ties resolve to the lowest index.
module waiz_argmax
    import waiz_pkg::*;
(
    input  logic [WIDTH*OUTPUT_SIZE-1:0] data,
    output logic [OUT_IDX_W-1:0]         idx
);

    word_t best_val;
    word_t cand;

    // Strict greater-than keeps the earlier index on ties.
    always_comb begin
        idx      = '0;
        best_val = word_t'(data[WIDTH-1:0]);
        cand     = '0;
        for (int unsigned i = 1; i < OUTPUT_SIZE; i++) begin
            cand = word_t'(data[i*WIDTH +: WIDTH]);
            if (cand > best_val) begin
                best_val = cand;
                idx      = OUT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/waiz_frame_sequencer.sv
// Assembles an input frame, fires the inference core, waits for completion under a
// timeout, then streams the captured results back out with a registered argmax.
module waiz_frame_sequencer
    import waiz_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    input  logic                          s_last,
    output logic                          core_start,
    output logic [WIDTH*INPUT_SIZE-1:0]   core_input_data,
    input  logic                          core_done,
    input  logic [WIDTH*OUTPUT_SIZE-1:0]  core_output_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data,
    output logic                          m_last,
    output logic [2:0]                    class_idx,
    output logic                          class_valid,
    output logic [CNT_W-1:0]              frame_count,
    output logic                          err_framing,
    output logic                          err_timeout,
    input  logic                          err_clear
);

    seq_state_t            state, state_next;
    word_t                 frame_buf [INPUT_SIZE];
    word_t                 out_reg   [OUTPUT_SIZE];
    logic [IN_IDX_W-1:0]   wr_idx;
    logic [OUT_IDX_W-1:0]  rd_idx;
    logic [TMR_W-1:0]      timer;
    logic [OUT_IDX_W-1:0]  argmax_idx;

    logic accept, frame_bad, frame_end, done_hit, tmo_hit, rd_accept, drain_end;

    waiz_argmax u_argmax (
        .data (core_output_data),
        .idx  (argmax_idx)
    );

    // Next-state and per-cycle strobes; done is checked before the timeout so it wins.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        frame_bad  = 1'b0;
        frame_end  = 1'b0;
        done_hit   = 1'b0;
        tmo_hit    = 1'b0;
        rd_accept  = 1'b0;
        drain_end  = 1'b0;
        case (state)
            ST_LOAD: begin
                if (s_valid) begin
                    accept = 1'b1;
                    if (wr_idx == IN_IDX_W'(INPUT_SIZE-1)) begin
                        if (s_last) begin
                            frame_end  = 1'b1;
                            state_next = ST_FIRE;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else if (s_last) begin
                        frame_bad = 1'b1;
                    end
                end
            end
            ST_FIRE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    done_hit   = 1'b1;
                    state_next = ST_DRAIN;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES-1)) begin
                    tmo_hit    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    rd_accept = 1'b1;
                    if (rd_idx == OUT_IDX_W'(OUTPUT_SIZE-1)) begin
                        drain_end  = 1'b1;
                        state_next = ST_LOAD;
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_LOAD;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < INPUT_SIZE; i++)  frame_buf[i] <= '0;
            for (int unsigned i = 0; i < OUTPUT_SIZE; i++) out_reg[i]   <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            timer       <= '0;
            core_start  <= 1'b0;
            class_idx   <= '0;
            class_valid <= 1'b0;
            frame_count <= '0;
            err_framing <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (accept) begin
                frame_buf[wr_idx] <= s_data;
                wr_idx <= (frame_bad || frame_end) ? '0 : wr_idx + IN_IDX_W'(1);
            end
            core_start <= (state_next == ST_FIRE);
            if (state == ST_FIRE)      timer <= '0;
            else if (state == ST_WAIT) timer <= timer + TMR_W'(1);
            if (done_hit) begin
                for (int unsigned i = 0; i < OUTPUT_SIZE; i++)
                    out_reg[i] <= core_output_data[i*WIDTH +: WIDTH];
                class_idx <= argmax_idx;
            end
            class_valid <= done_hit;
            if (drain_end)      rd_idx <= '0;
            else if (rd_accept) rd_idx <= rd_idx + OUT_IDX_W'(1);
            if (drain_end) frame_count <= frame_count + CNT_W'(1);
            // Sticky flags: a new error in the clear cycle takes precedence.
            err_framing <= frame_bad | (err_framing & ~err_clear);
            err_timeout <= tmo_hit   | (err_timeout & ~err_clear);
        end
    end

    always_comb begin
        core_input_data = '0;
        for (int unsigned i = 0; i < INPUT_SIZE; i++)
            core_input_data[i*WIDTH +: WIDTH] = frame_buf[i];
    end

    // Stream-side handshakes decode from state and registers only.
    assign s_ready = (state == ST_LOAD);
    assign m_valid = (state == ST_DRAIN);
    assign m_data  = out_reg[rd_idx];
    assign m_last  = (rd_idx == OUT_IDX_W'(OUTPUT_SIZE-1));

endmodule

// File: tb/tb_waiz_frame_sequencer.sv
// Directed scoreboard bench for waiz_frame_sequencer with a simple delayed-done core model.
module tb_waiz_frame_sequencer;

    localparam int W   = 16;
    localparam int NI  = 16;
    localparam int NO  = 5;
    localparam int TMO = 1024;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            s_valid, s_ready, s_last;
    logic [W-1:0]    s_data;
    logic            core_start, core_done;
    logic [W*NI-1:0] core_input_data;
    logic [W*NO-1:0] core_output_data;
    logic            m_valid, m_ready, m_last;
    logic [W-1:0]    m_data;
    logic [2:0]      class_idx;
    logic            class_valid;
    logic [15:0]     frame_count;
    logic            err_framing, err_timeout, err_clear;

    int n_assert = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int s0;
    bit seen;

    logic signed [15:0] exp_q[$];
    int cur_frame[NI];
    int nom_frame[NI] = '{-304, 378, 253, -8, 123, 14, -399, -144,
                          -399, -629, -664, -537, -586, -376, 284, 430};

    always #5 clk = ~clk;

    waiz_frame_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .core_start       (core_start),
        .core_input_data  (core_input_data),
        .core_done        (core_done),
        .core_output_data (core_output_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .class_idx        (class_idx),
        .class_valid      (class_valid),
        .frame_count      (frame_count),
        .err_framing      (err_framing),
        .err_timeout      (err_timeout),
        .err_clear        (err_clear)
    );

    always @(negedge clk) if (reset_n === 1'b1 && core_start === 1'b1) start_cnt++;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_core_out(input int a, input int b, input int c, input int d, input int e);
        int v[NO];
        v = '{a, b, c, d, e};
        for (int i = 0; i < NO; i++) begin
            core_output_data[i*W +: W] = 16'(v[i]);
            exp_q.push_back(16'(v[i]));
        end
    endtask

    task automatic send_frame(input int last_pos, input int n);
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 16'(cur_frame[w]);
            s_last  = (w == last_pos);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (core_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_core(input int delay, input int exp_cls);
        bit got;
        wait_start(got);
        check("core_start_seen", 32'(got), 1);
        if (got) begin
            for (int i = 0; i < NI; i++)
                check("core_input_data", $signed(core_input_data[i*W +: W]), cur_frame[i]);
            repeat (delay) @(negedge clk);
            check("s_ready_in_wait", 32'(s_ready), 0);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            check("class_valid_pulse", 32'(class_valid), 1);
            check("class_idx", 32'(class_idx), exp_cls);
            check("m_valid_after_done", 32'(m_valid), 1);
        end
    endtask

    task automatic drain(input int mode, input int stop_after);
        int acc = 0;
        int cyc = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (acc < stop_after && cyc < 100) begin
            if (m_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                    m_ready = 1'b0;
                end else begin
                    check("m_data", $signed(m_data), exp_q[0]);
                    check("m_last", 32'(m_last), (exp_q.size() == 1) ? 1 : 0);
                    m_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        acc++;
                    end
                end
            end else begin
                m_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        check("drain_words", acc, stop_after);
    endtask

    task automatic end_of_frame(input int exp_fc);
        check("m_valid_idle", 32'(m_valid), 0);
        check("frame_count", 32'(frame_count), exp_fc);
        check("s_ready_idle", 32'(s_ready), 1);
        check("class_valid_low", 32'(class_valid), 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        core_done = 1'b0; core_output_data = '0; m_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_core_start", 32'(core_start), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_errors", 32'({err_framing, err_timeout}), 0);
        check("rst_class_idx", 32'(class_idx), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal frame with tie in outputs.
        cur_frame = nom_frame;
        set_core_out(-50, 12, 700, 700, -3);
        s0 = start_cnt;
        send_frame(15, NI);
        run_core(20, 2);
        drain(0, NO);
        end_of_frame(1);
        repeat (3) @(negedge clk);
        check("single_start_pulse", start_cnt - s0, 1);

        // Output backpressure 1-0-0-1.
        for (int i = 0; i < NI; i++) cur_frame[i] = i * 37 - 200;
        set_core_out(5, -7, 3, 9, 9);
        send_frame(15, NI);
        run_core(5, 3);
        drain(1, NO);
        end_of_frame(2);

        // Framing error followed by a clean frame.
        do_reset();
        cur_frame = nom_frame;
        s0 = start_cnt;
        send_frame(7, 8);
        repeat (3) @(negedge clk);
        check("err_framing_set", 32'(err_framing), 1);
        check("no_start_on_bad_frame", start_cnt - s0, 0);
        check("s_ready_after_bad", 32'(s_ready), 1);
        set_core_out(-1, -2, -3, -4, -5);
        send_frame(15, NI);
        run_core(3, 0);
        drain(0, NO);
        end_of_frame(1);
        check("err_framing_sticky", 32'(err_framing), 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_framing_cleared", 32'(err_framing), 0);

        // Timeout: core never completes.
        for (int i = 0; i < NI; i++) cur_frame[i] = 1000 - i * 111;
        send_frame(15, NI);
        wait_start(seen);
        check("tmo_start_seen", 32'(seen), 1);
        repeat (TMO) @(negedge clk);
        check("err_timeout_not_early", 32'(err_timeout), 0);
        @(negedge clk);
        check("err_timeout_set", 32'(err_timeout), 1);
        check("s_ready_after_tmo", 32'(s_ready), 1);
        check("m_valid_after_tmo", 32'(m_valid), 0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("done_ignored_in_load", 32'(class_valid), 0);
        check("no_drain_in_load", 32'(m_valid), 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_timeout_cleared", 32'(err_timeout), 0);

        // Done exactly at the terminal timer count.
        set_core_out(100, -100, 0, 100, 200);
        send_frame(15, NI);
        run_core(TMO, 4);
        check("terminal_no_timeout", 32'(err_timeout), 0);
        drain(0, NO);
        end_of_frame(2);
        check("terminal_no_timeout_after", 32'(err_timeout), 0);

        // Reset in the middle of draining.
        set_core_out(1, 2, 3, 4, 5);
        send_frame(15, NI);
        run_core(2, 4);
        drain(0, 2);
        check("mid_drain_valid", 32'(m_valid), 1);
        reset_n = 1'b0;
        #1;
        check("rst_async_m_valid", 32'(m_valid), 0);
        check("rst_async_m_data", 32'(m_data), 0);
        check("rst_async_m_last", 32'(m_last), 0);
        check("rst_async_frame_count", 32'(frame_count), 0);
        check("rst_async_class_idx", 32'(class_idx), 0);
        check("rst_async_buffer_zero", 32'(core_input_data === '0), 1);
        check("rst_async_core_start", 32'(core_start), 0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 1);
        check("post_rst_frame_count", 32'(frame_count), 0);
        check("post_rst_m_valid", 32'(m_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
